// File: rtl/k2mm_out_serializer.sv
// rtl/k2mm_out_serializer.sv - two-channel FIFO, round-robin arbiter and framed nibble serializer
//
// Buffers the k2mm E_out_0 / E_out_1 ap_fifo streams and sends each word as a
// frame on a 4-bit pin bus: header {2'b10,1'b0,ch}, DATA_W/4 data nibbles MSB
// first, and optionally an XOR checksum nibble.
//
// Ports:
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   E_out_N_din/_write      channel N write data and strobe
//   E_out_N_full_n          channel N FIFO has a free slot
//   data_out, data_valid    registered nibble and its qualifier
//   probe_out               registered, inverts on the last nibble of each frame
//
// Build option: define SER_CHKSUM_EN to append the checksum nibble.

module k2mm_out_serializer_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              write,
  output logic              full_n,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [AW:0] FULL_CNT = DEPTH_U[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic              push;

  // A push while full is rejected even if a pop frees a slot this cycle.
  assign full_n = (count != FULL_CNT);
  assign empty  = (count == '0);
  assign push   = write && full_n;
  assign dout   = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module k2mm_out_serializer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DATA_W-1:0] E_out_0_din,
  input  logic              E_out_0_write,
  output logic              E_out_0_full_n,
  input  logic [DATA_W-1:0] E_out_1_din,
  input  logic              E_out_1_write,
  output logic              E_out_1_full_n,
  output logic [3:0]        data_out,
  output logic              data_valid,
  output logic              probe_out
);
  localparam int NN = DATA_W / 4;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);

`ifdef SER_CHKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [3:0]        data_out_d;
  logic              data_valid_d;
  logic              toggle;
  logic              start;
  logic              start_any;
  logic              start_ch;
  logic [DATA_W-1:0] start_word;
  logic              pop0, pop1;
  logic [DATA_W-1:0] f0_dout, f1_dout;
  logic              f0_empty, f1_empty;
`ifdef SER_CHKSUM_EN
  logic [3:0]        csum_q, csum_d;
`endif

  k2mm_out_serializer_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk(ap_clk), .rst_n(ap_rst_n), .din(E_out_0_din), .write(E_out_0_write),
    .full_n(E_out_0_full_n), .pop(pop0), .dout(f0_dout), .empty(f0_empty)
  );

  k2mm_out_serializer_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk(ap_clk), .rst_n(ap_rst_n), .din(E_out_1_din), .write(E_out_1_write),
    .full_n(E_out_1_full_n), .pop(pop1), .dout(f1_dout), .empty(f1_empty)
  );

  // Round-robin pick: with both pending, serve the channel not served last.
  always_comb begin
    start_any = !f0_empty || !f1_empty;
    if (!f0_empty && !f1_empty) start_ch = ~last_q;
    else                        start_ch = f0_empty;
    start_word = start_ch ? f1_dout : f0_dout;
  end

  // Next-state logic also computes the value the output flops take, so each
  // state's nibble is on the pins in the same cycle the state is current.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    data_out_d   = 4'h0;
    data_valid_d = 1'b0;
    toggle       = 1'b0;
    start        = 1'b0;
    pop0         = 1'b0;
    pop1         = 1'b0;
`ifdef SER_CHKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE: start = 1'b1;
      S_HDR: begin
        state_d      = S_DATA;
        cnt_d        = '0;
        data_out_d   = shreg_q[DATA_W-1 -: 4];
        shreg_d      = shreg_q << 4;
        data_valid_d = 1'b1;
`ifdef SER_CHKSUM_EN
        csum_d       = csum_q ^ shreg_q[DATA_W-1 -: 4];
`else
        toggle       = (NN == 1);
`endif
      end
      S_DATA: begin
        if (cnt_q != LAST_IDX) begin
          cnt_d        = cnt_q + CW'(1);
          data_out_d   = shreg_q[DATA_W-1 -: 4];
          shreg_d      = shreg_q << 4;
          data_valid_d = 1'b1;
`ifdef SER_CHKSUM_EN
          csum_d       = csum_q ^ shreg_q[DATA_W-1 -: 4];
`else
          toggle       = (cnt_d == LAST_IDX);
`endif
        end else begin
`ifdef SER_CHKSUM_EN
          state_d      = S_CSUM;
          data_out_d   = csum_q;
          data_valid_d = 1'b1;
          toggle       = 1'b1;
`else
          start        = 1'b1;
`endif
        end
      end
`ifdef SER_CHKSUM_EN
      S_CSUM: start = 1'b1;
`endif
      default: state_d = S_IDLE;
    endcase

    // Frame start from IDLE or directly at frame end, so frames run back-to-back.
    if (start) begin
      if (start_any) begin
        state_d      = S_HDR;
        shreg_d      = start_word;
        last_d       = start_ch;
        pop0         = !start_ch;
        pop1         = start_ch;
        data_out_d   = {3'b100, start_ch};
        data_valid_d = 1'b1;
`ifdef SER_CHKSUM_EN
        csum_d       = 4'h0;
`endif
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      data_out   <= 4'h0;
      data_valid <= 1'b0;
      probe_out  <= 1'b0;
`ifdef SER_CHKSUM_EN
      csum_q     <= 4'h0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      probe_out  <= probe_out ^ toggle;
`ifdef SER_CHKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_k2mm_out_serializer.sv
// tb/tb_k2mm_out_serializer.sv - self-checking bench for k2mm_out_serializer

module tb_k2mm_out_serializer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int NN     = DATA_W / 4;
`ifdef SER_CHKSUM_EN
  localparam int N = NN + 2;
`else
  localparam int N = NN + 1;
`endif

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic [DATA_W-1:0] E_out_0_din, E_out_1_din;
  logic              E_out_0_write, E_out_1_write;
  logic              E_out_0_full_n, E_out_1_full_n;
  logic [3:0]        data_out;
  logic              data_valid, probe_out;

  k2mm_out_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .E_out_0_din(E_out_0_din), .E_out_0_write(E_out_0_write), .E_out_0_full_n(E_out_0_full_n),
    .E_out_1_din(E_out_1_din), .E_out_1_write(E_out_1_write), .E_out_1_full_n(E_out_1_full_n),
    .data_out(data_out), .data_valid(data_valid), .probe_out(probe_out)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Reference model: per-channel word queues, frame-level scheduler, and the
  // expected pin value for each future cycle.
  logic [DATA_W-1:0] q0[$], q1[$];
  int                m_next_dec;
  bit                m_last, m_probe;
  logic [3:0]        e_d[int];
  bit                e_t[int];

  logic [3:0] tr_d[$];
  bit         tr_v[$], tr_p[$], tr_f1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  function automatic void model_reset();
    q0.delete(); q1.delete(); e_d.delete(); e_t.delete();
    m_last = 1'b1; m_probe = 1'b0; m_next_dec = 0;
  endfunction

  function automatic void schedule(input bit ch, input logic [DATA_W-1:0] w, input int t);
`ifdef SER_CHKSUM_EN
    logic [3:0] x = 4'h0;
`endif
    e_d[t+1] = {3'b100, ch};
    for (int k = 0; k < NN; k++) begin
      e_d[t+2+k] = w[DATA_W-1-4*k -: 4];
`ifdef SER_CHKSUM_EN
      x ^= w[DATA_W-1-4*k -: 4];
`endif
    end
`ifdef SER_CHKSUM_EN
    e_d[t+2+NN] = x;
`endif
    e_t[t+N] = 1'b1;
  endfunction

  // One clock cycle: compare this cycle's pins with the model, then drive the
  // inputs that the next rising edge samples.
  task automatic step(input bit w0, input logic [DATA_W-1:0] d0,
                      input bit w1, input logic [DATA_W-1:0] d1, input bit rst);
    logic [7:0] act, exp;
    logic [3:0] ed;
    bit ev, a0, a1, ch;
    logic [DATA_W-1:0] w;
    @(negedge ap_clk);
    cyc++;
    if (e_t.exists(cyc)) m_probe = ~m_probe;
    ev  = e_d.exists(cyc);
    ed  = ev ? e_d[cyc] : 4'h0;
    act = {1'b0, E_out_0_full_n, E_out_1_full_n, data_valid, data_out, probe_out} >> 0;
    act = {E_out_0_full_n, E_out_1_full_n, data_valid, data_out, probe_out};
    exp = {(q0.size() != DEPTH), (q1.size() != DEPTH), ev, ed, m_probe};
    check("pins", {24'h0, act}, {24'h0, exp});
    tr_d.push_back(data_out); tr_v.push_back(data_valid);
    tr_p.push_back(probe_out); tr_f1.push_back(E_out_1_full_n);
    if (rst) begin
      ap_rst_n = 1'b0;
      E_out_0_write = 1'b0; E_out_1_write = 1'b0;
      #1;
      check("rst_pins", {26'h0, data_valid, data_out, probe_out},
            {26'h0, 1'b0, 4'h0, 1'b0});
      check("rst_full_n", {30'h0, E_out_0_full_n, E_out_1_full_n}, 32'h3);
      model_reset();
    end else begin
      ap_rst_n = 1'b1;
      a0 = w0 && (q0.size() != DEPTH);
      a1 = w1 && (q1.size() != DEPTH);
      if (cyc >= m_next_dec && (q0.size() != 0 || q1.size() != 0)) begin
        ch = (q0.size() != 0 && q1.size() != 0) ? ~m_last : (q1.size() != 0);
        w  = ch ? q1.pop_front() : q0.pop_front();
        m_last = ch;
        schedule(ch, w, cyc);
        m_next_dec = cyc + N;
      end
      if (a0) q0.push_back(d0);
      if (a1) q1.push_back(d1);
      E_out_0_write = w0; E_out_0_din = d0;
      E_out_1_write = w1; E_out_1_din = d1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    idle(1);
  endtask

  function automatic int count_valid(input int a, input int b);
    int c = 0;
    for (int i = a; i < b; i++) if (tr_v[i]) c++;
    return c;
  endfunction

  function automatic int toggles(input int a, input int b);
    int c = 0;
    for (int i = a + 1; i < b; i++) if (tr_p[i] != tr_p[i-1]) c++;
    return c;
  endfunction

  typedef struct {
    bit                w0;
    logic [DATA_W-1:0] d0;
    bit                ev;
    logic [3:0]        ed;
    bit                ep;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int i0, n;
    int thr;
    logic [DATA_W-1:0] sw;

    model_reset();
    ap_rst_n = 1'b1;
    E_out_0_write = 1'b0; E_out_1_write = 1'b0;
    E_out_0_din = '0; E_out_1_din = '0;
    #2 ap_rst_n = 1'b0;
    do_reset();

    // Single word, table-driven.
    sw = 32'h1234_ABCD;
    tbl.push_back('{1'b1, sw, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 4'h8, 1'b0});
    for (int k = 0; k < NN; k++)
      tbl.push_back('{1'b0, 32'h0, 1'b1, sw[DATA_W-1-4*k -: 4], (k == NN-1) && (N == NN+1)});
`ifdef SER_CHKSUM_EN
    tbl.push_back('{1'b0, 32'h0, 1'b1, 4'h4, 1'b1});
`endif
    tbl.push_back('{1'b0, 32'h0, 1'b0, 4'h0, 1'b1});
    foreach (tbl[i]) begin
      step(tbl[i].w0, tbl[i].d0, 1'b0, '0, 1'b0);
      n = tr_v.size() - 1;
      check($sformatf("vec%0d", i), {26'h0, tr_v[n], tr_d[n], tr_p[n]},
            {26'h0, tbl[i].ev, tbl[i].ed, tbl[i].ep});
    end

    // Simultaneous first words: ch0 frame then ch1 frame, no gap.
    do_reset();
    i0 = tr_v.size();
    step(1'b1, 32'h0000_0001, 1'b1, 32'h1111_1111, 1'b0);
    idle(2*N + 6);
    check("simul_hdr0", {27'h0, tr_v[i0+2], tr_d[i0+2]}, {27'h0, 1'b1, 4'h8});
    check("simul_hdr1", {27'h0, tr_v[i0+2+N], tr_d[i0+2+N]}, {27'h0, 1'b1, 4'h9});
    check("simul_run", count_valid(i0 + 2, i0 + 2 + 2*N), 2*N);

    // Fairness: four words per channel.
    do_reset();
    i0 = tr_v.size();
    for (int k = 0; k < DEPTH; k++) step(1'b1, $urandom, 1'b1, $urandom, 1'b0);
    idle(8*N + 20);
    check("fair_valid", count_valid(i0, i0 + 8*N + 20), 8*N);
    check("fair_run", count_valid(i0 + 2, i0 + 2 + 8*N), 8*N);
    check("fair_probe", toggles(i0, i0 + 8*N + 20), 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("fair_hdr%0d", k), {28'h0, tr_d[i0+2+N*k]}, {28'h0, 3'b100, k[0]});

    // Backpressure: five ch1 words while a ch0 frame is on the pins.
    do_reset();
    i0 = tr_v.size();
    step(1'b1, $urandom, 1'b0, '0, 1'b0);
    idle(2);
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1, 32'hB0B0_0000 + k, 1'b0);
    idle(5*N + 10);
    check("bp_full_after3", {31'h0, tr_f1[i0+6]}, 32'h1);
    check("bp_full_after4", {31'h0, tr_f1[i0+7]}, 32'h0);
    check("bp_ch1_frames", count_valid(i0 + 2 + N, i0 + 6*N + 10), 4*N);
    for (int k = 0; k < 4; k++)
      check($sformatf("bp_hdr%0d", k), {28'h0, tr_d[i0+2+N*(k+1)]}, 32'h9);

    // Reset during data nibble 3.
    do_reset();
    i0 = tr_v.size();
    step(1'b1, 32'hCAFE_F00D, 1'b0, '0, 1'b0);
    for (int k = 0; k < DEPTH; k++) step(1'b0, '0, 1'b1, $urandom, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    check("mid_state", {27'h0, tr_v[i0+6], tr_f1[i0+6], tr_d[i0+6]},
          {27'h0, 1'b1, 1'b0, 4'hE});
    step(1'b0, '0, 1'b0, '0, 1'b1);
    i0 = tr_v.size();
    step(1'b1, 32'h5A5A_0F0F, 1'b0, '0, 1'b0);
    idle(N + 4);
    check("post_rst_gap", {31'h0, tr_v[i0+1]}, 32'h0);
    check("post_rst_hdr", {27'h0, tr_v[i0+2], tr_d[i0+2]}, {27'h0, 1'b1, 4'h8});
    check("post_rst_len", count_valid(i0, i0 + N + 5), N);

    // Random traffic against the model, with one reset in the middle.
    for (int seg = 0; seg < 8; seg++) begin
      thr = 1 + (seg % 3);
      for (int c = 0; c < 100; c++) begin
        if (seg == 5 && c == 50) step(1'b0, '0, 1'b0, '0, 1'b1);
        else step($urandom_range(0, 3) < thr, $urandom, $urandom_range(0, 3) < thr, $urandom, 1'b0);
      end
    end
    idle(2*DEPTH*N + 10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/k2mm_out_serializer.md
# k2mm_out_serializer

Output-port scheduler for the k2mm kernel. It accepts the two HLS `ap_fifo` output streams E_out_0 and E_out_1, buffers each in a small FIFO, and arbitrates round-robin between them. The selected word is serialized as a framed nibble stream onto the 4-bit `data_out`/`data_valid` pins of the board wrapper, and `probe_out` toggles once per completed frame.

## Interface
- `DATA_W`, 32: stream word width; must be a multiple of 4.
- `DEPTH`, 4: per-channel FIFO depth; power of 2, ≥2.

Ports:
- `ap_clk` in 1: single clock for the whole block.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `E_out_0_din` in DATA_W: channel 0 write data.
- `E_out_0_write` in 1: channel 0 write strobe.
- `E_out_0_full_n` out 1: channel 0 FIFO not full.
- `E_out_1_din` in DATA_W: channel 1 write data.
- `E_out_1_write` in 1: channel 1 write strobe.
- `E_out_1_full_n` out 1: channel 1 FIFO not full.
- `data_out` out 4: serialized nibble, registered.
- `data_valid` out 1: `data_out` carries a frame nibble, registered.
- `probe_out` out 1: toggles on the last nibble of each frame, registered.

## Operation
- **Reset values.** All outputs are 0 except both `full_n`, which are 1. FIFOs are empty, FSM is IDLE, and the round-robin pointer is `last=1`, so channel 0 wins first.
- **FIFO write.** A write is accepted when `write && full_n`. A write with `full_n=0` is ignored and the count is unchanged.
- **FIFO full flag.** `full_n = (count != DEPTH)`.
- **Simultaneous push and pop on one channel.** The count is unchanged. A push when full is still rejected, even if a pop happens in the same cycle.
- **Frame format, in order:**
  - Header nibble `{2'b10, 1'b0, ch}`.
  - DATA_W/4 data nibbles, MSB first.
  - Optional checksum nibble (see Configuration).
  - Frame length N is 1+DATA_W/4, i.e. 9 nibbles for DATA_W=32.
- **FSM states:**
  - IDLE: when any FIFO is non-empty, pick a channel, pop it, load the shift register, and go to HDR.
  - HDR: drive the header nibble, then go to DATA with the nibble counter at 0.
  - DATA: shift out one nibble per cycle. After nibble DATA_W/4-1, go to CSUM if enabled; otherwise end the frame.
  - CSUM (only with the macro): drive the checksum nibble, then end the frame.
- **Frame end.** When any FIFO is non-empty, pop and go directly to HDR with no idle gap. Otherwise go to IDLE.
- **Arbitration** is evaluated only at IDLE→HDR and at frame end:
  - Both channels non-empty: serve the channel ≠ `last`.
  - One channel non-empty: serve it.
  - `last` updates to the served channel.
- **`data_valid`** is 1 in every cycle a frame nibble is driven and 0 otherwise. In IDLE, `data_out` is 0.
- **`probe_out`** inverts in the cycle the final nibble of a frame is driven.
- **Mid-frame reset.** Assertion of `ap_rst_n` clears everything immediately: the partial frame is abandoned and FIFO contents are lost.

## Timing
- **Latency.** A write in cycle c into an empty FIFO, with the FSM idle, gives the header in cycle c+2 and data nibble k in cycle c+3+k.
- **Throughput.** One word per N cycles for the whole block. Data nibbles are gap-free inside a frame. Frames are back-to-back while data is pending.
- **Output timing.** No backpressure on the output pins. All outputs come directly from flops.
- **`full_n`** reflects the count registered at the previous edge. The kernel sees a slot freed by a pop one cycle after the pop.

## Configuration
- **`SER_CHKSUM_EN` defined:**
  - CSUM state is present and N = 2+DATA_W/4.
  - The final nibble is the XOR of all DATA_W/4 data nibbles; the header is excluded.
  - `probe_out` toggles on the checksum nibble.
- **Not defined:** CSUM state and the XOR logic are absent, and N = 1+DATA_W/4.

## Test plan
- **Single word.** Reset, then write `E_out_0_din=32'h1234_ABCD` once. Expect a 9-cycle burst `8,1,2,3,4,A,B,C,D` starting 2 cycles after the write, `data_valid` high exactly 9 cycles, and `probe_out` 0→1 on the `D` nibble.
- **Simultaneous first words.** Write ch0 `32'h0000_0001` and ch1 `32'h1111_1111` in the same cycle. Expect the ch0 frame (header `8`) immediately followed by the ch1 frame (header `9`), with no gap between them.
- **Fairness.** Fill both FIFOs with 4 words each. Expect headers alternating `8,9,8,9,8,9,8,9`, 72 consecutive valid cycles, and `probe_out` toggling 8 times.
- **Backpressure.** Write 5 words to ch1 back-to-back while a ch0 frame is in progress. Expect `E_out_1_full_n`=0 after the 4th accepted word, the 5th word dropped, and exactly 4 ch1 frames out.
- **Reset mid-frame.** Assert `ap_rst_n`=0 during data nibble 3. Expect `data_valid`/`data_out`/`probe_out`=0 and `full_n`=1 immediately; after release, a new write produces a clean frame.
- **Checksum, with `SER_CHKSUM_EN`.** Write ch0 `32'h1234_ABCD`. Expect 10 nibbles ending in checksum `4`; `probe_out` toggles on that nibble.
